// File: rtl/sa_inst_pkg.sv
// Shared definitions for the systolic-array instruction path: opcodes, field positions, sequencer FSM states.
package sa_inst_pkg;

  localparam int OPCODE_BITS_DEF = 4;
  localparam int ADDR_BITS_DEF   = 8;
  localparam int INST_BITS_DEF   = OPCODE_BITS_DEF + 2*ADDR_BITS_DEF;

  localparam logic [3:0] IDLE_INST          = 4'h0;
  localparam logic [3:0] AXI_TO_UB_INST     = 4'h1;
  localparam logic [3:0] UB_TO_WEIGHT_INST  = 4'h2;
  localparam logic [3:0] MAT_MUL_INST       = 4'h3;
  localparam logic [3:0] ACC_TO_UB_INST     = 4'h4;
  localparam logic [3:0] UB_TO_AXI_INST     = 4'h5;

  // Word layout is {OPCODE, ADDRA, ADDRB}, MSB first.
  localparam int OPCODE_FROM = INST_BITS_DEF - 1;
  localparam int OPCODE_TO   = 2*ADDR_BITS_DEF;
  localparam int ADDRA_FROM  = 2*ADDR_BITS_DEF - 1;
  localparam int ADDRA_TO    = ADDR_BITS_DEF;
  localparam int ADDRB_FROM  = ADDR_BITS_DEF - 1;
  localparam int ADDRB_TO    = 0;

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_WAIT_HI = 2'd1;
  localparam logic [1:0] ST_WAIT_LO = 2'd2;

  function automatic logic [INST_BITS_DEF-1:0] mk_inst(input logic [OPCODE_BITS_DEF-1:0] op,
                                                       input logic [ADDR_BITS_DEF-1:0] a,
                                                       input logic [ADDR_BITS_DEF-1:0] b);
    return {op, a, b};
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO holding queued instruction entries; count and full are registered.
module inst_fifo #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              push_ok, pop_ok;

  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    full_d   = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = (count_q == '0);

endmodule

// File: rtl/inst_sequencer.sv
// Instruction issue stage feeding SYSTOLIC_ARRAY: host FIFO plus flag-handshake FSM.
// Define INST_SEQ_REPEAT_EN to add per-entry repeat count and ADDRA/ADDRB strides.
module inst_sequencer
  import sa_inst_pkg::*;
#(
  parameter int OPCODE_BITS = 4,
  parameter int ADDR_BITS   = 8,
  parameter int INST_BITS   = OPCODE_BITS + 2*ADDR_BITS,
  parameter int FIFO_DEPTH  = 16,
  parameter int RPT_BITS    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic [INST_BITS-1:0]          push_inst,
`ifdef INST_SEQ_REPEAT_EN
  input  logic [RPT_BITS-1:0]           push_rpt,
  input  logic [ADDR_BITS-1:0]          push_stride_a,
  input  logic [ADDR_BITS-1:0]          push_stride_b,
`endif
  output logic [INST_BITS-1:0]          instruction,
  input  logic                          flag,
  input  logic                          idle_flag,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   issued_cnt
);

  localparam int OP_HI = INST_BITS - 1;
  localparam int OP_LO = 2*ADDR_BITS;
  localparam int A_HI  = 2*ADDR_BITS - 1;
  localparam int A_LO  = ADDR_BITS;
  localparam int B_HI  = ADDR_BITS - 1;
  localparam logic [OPCODE_BITS-1:0] IDLE_OP   = OPCODE_BITS'(IDLE_INST);
  localparam logic [INST_BITS-1:0]   IDLE_WORD = {IDLE_OP, {(2*ADDR_BITS){1'b0}}};

  if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_DEPTH < 2) || (RPT_BITS < 1)) begin : g_bad_cfg
    $error("inst_sequencer: FIFO_DEPTH must be a power of two >= 2 and RPT_BITS >= 1");
  end

`ifdef INST_SEQ_REPEAT_EN
  localparam int ENT_W = INST_BITS + RPT_BITS + 2*ADDR_BITS;
`else
  localparam int ENT_W = INST_BITS;
`endif

  logic [ENT_W-1:0]     push_ent, pop_ent;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [1:0]           state_q, state_d;
  logic [INST_BITS-1:0] inst_q, inst_d;
  logic [15:0]          issued_q, issued_d;

`ifdef INST_SEQ_REPEAT_EN
  logic [RPT_BITS-1:0]  rpt_left_q, rpt_left_d;
  logic [ADDR_BITS-1:0] stride_a_q, stride_a_d, stride_b_q, stride_b_d;
  assign push_ent = {push_rpt, push_stride_a, push_stride_b, push_inst};
`else
  assign push_ent = push_inst;
`endif

  inst_fifo #(.DATA_W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push_valid),
    .push_data (push_ent),
    .pop       (fifo_pop),
    .pop_data  (pop_ent),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    issued_d = issued_q;
    fifo_pop = 1'b0;
`ifdef INST_SEQ_REPEAT_EN
    rpt_left_d = rpt_left_q;
    stride_a_d = stride_a_q;
    stride_b_d = stride_b_q;
`endif
    case (state_q)
      ST_LOAD: begin
        state_d = ST_WAIT_HI;
`ifdef INST_SEQ_REPEAT_EN
        // Pending repeats reuse the held word and bypass the FIFO entirely.
        if (rpt_left_q != '0) begin
          inst_d     = {inst_q[OP_HI:OP_LO], inst_q[A_HI:A_LO] + stride_a_q, inst_q[B_HI:0] + stride_b_q};
          rpt_left_d = rpt_left_q - RPT_BITS'(1);
        end else
`endif
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          inst_d   = pop_ent[INST_BITS-1:0];
`ifdef INST_SEQ_REPEAT_EN
          rpt_left_d = pop_ent[ENT_W-1 -: RPT_BITS];
          stride_a_d = pop_ent[INST_BITS+2*ADDR_BITS-1 -: ADDR_BITS];
          stride_b_d = pop_ent[INST_BITS+ADDR_BITS-1 -: ADDR_BITS];
`endif
        end else begin
          inst_d = IDLE_WORD;
        end
      end
      ST_WAIT_HI: if (flag) state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!flag) begin
          if (inst_q[OP_HI:OP_LO] != IDLE_OP) issued_d = issued_q + 16'd1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_LOAD;
      inst_q   <= IDLE_WORD;
      issued_q <= '0;
`ifdef INST_SEQ_REPEAT_EN
      rpt_left_q <= '0;
      stride_a_q <= '0;
      stride_b_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      issued_q <= issued_d;
`ifdef INST_SEQ_REPEAT_EN
      rpt_left_q <= rpt_left_d;
      stride_a_q <= stride_a_d;
      stride_b_q <= stride_b_d;
`endif
    end
  end

  assign instruction = inst_q;
  assign issued_cnt  = issued_q;
  assign push_ready  = ~fifo_full;
  assign busy        = (fifo_count != '0) | (inst_q[OP_HI:OP_LO] != IDLE_OP) | ~idle_flag;

endmodule
